// File: rtl/loop_pkg.sv
// Shared state encoding and default widths for the hardware for-loop sequencer.
package loop_pkg;

  localparam int DEF_IDX_W  = 4;
  localparam int DEF_GAP_W  = 8;
  localparam int DEF_WDOG_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_ISSUE = 2'd2
  } loopState_e;

endpackage

// File: rtl/loop_wdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the cycle
// in which the count reaches a non-zero limit.
module loop_wdog
  import loop_pkg::*;
#(
  parameter int WDOG_W = DEF_WDOG_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic [WDOG_W-1:0] limit_i,
  output logic              fire_o
);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;
  logic [WDOG_W-1:0] cntInc;

  always_comb begin
    cntInc = cnt_q + WDOG_W'(1);
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cntInc;
    end
  end

  // Fires in the cycle the count would reach the limit; a clear in that cycle wins.
  assign fire_o = en_i && !clear_i && (limit_i != '0) && (cntInc == limit_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/loop_iter_gen.sv
// Hardware for-loop sequencer: walks first..last by step with an idle gap before
// each index, offering indices on a valid/ready stream, guarded by a watchdog.
module loop_iter_gen
  import loop_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int GAP_W  = DEF_GAP_W,
  parameter int WDOG_W = DEF_WDOG_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [IDX_W-1:0]  cfg_first_i,
  input  logic [IDX_W-1:0]  cfg_last_i,
  input  logic [IDX_W-1:0]  cfg_step_i,
  input  logic [GAP_W-1:0]  cfg_gap_i,
  input  logic [WDOG_W-1:0] wdog_limit_i,
  output logic              iter_valid_o,
  input  logic              iter_ready_i,
  output logic [IDX_W-1:0]  iter_idx_o,
  output logic              iter_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o
);

  loopState_e       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] cfgLast_q;
  logic [IDX_W-1:0] cfgStep_q;
  logic [GAP_W-1:0] cfgGap_q;
  logic [GAP_W-1:0] gapCnt_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;

  logic [IDX_W-1:0] stepEff;
  logic             xfer;
  logic             startOk;
  logic             wdogFire;
  logic             endRun;

  // One extra bit keeps the carry, so an index that would wrap is treated as past the end.
  function automatic logic lastAfter(input logic [IDX_W-1:0] base,
                                     input logic [IDX_W-1:0] step,
                                     input logic [IDX_W-1:0] limit);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    return sum > {1'b0, limit};
  endfunction

  assign stepEff = (cfg_step_i == '0) ? IDX_W'(1) : cfg_step_i;
  assign xfer    = valid_q && iter_ready_i;
  assign startOk = start_i && (state_q == ST_IDLE);
  assign endRun  = abort_i || wdogFire || (xfer && last_q);

  loop_wdog #(.WDOG_W(WDOG_W)) uWdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (busy_q),
    .clear_i (xfer || startOk),
    .limit_i (wdog_limit_i),
    .fire_o  (wdogFire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cfgLast_q <= '0;
      cfgStep_q <= '0;
      cfgGap_q  <= '0;
      gapCnt_q  <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cfgLast_q <= cfg_last_i;
            cfgStep_q <= stepEff;
            cfgGap_q  <= cfg_gap_i;
            if (cfg_first_i > cfg_last_i) begin
              done_q <= 1'b1;
            end else begin
              busy_q   <= 1'b1;
              idx_q    <= cfg_first_i;
              last_q   <= lastAfter(cfg_first_i, stepEff, cfg_last_i);
              gapCnt_q <= cfg_gap_i;
              if (cfg_gap_i == '0) begin
                state_q <= ST_ISSUE;
                valid_q <= 1'b1;
              end else begin
                state_q <= ST_GAP;
              end
            end
          end
        end
        ST_GAP, ST_ISSUE: begin
          // Abort outranks the watchdog, which outranks a normal final transfer.
          if (endRun) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            timeout_q <= !abort_i && wdogFire;
            done_q    <= !abort_i && !wdogFire;
          end else if (state_q == ST_GAP) begin
            if (gapCnt_q <= GAP_W'(1)) begin
              state_q <= ST_ISSUE;
              valid_q <= 1'b1;
            end else begin
              gapCnt_q <= gapCnt_q - GAP_W'(1);
            end
          end else if (xfer) begin
            idx_q  <= idx_q + cfgStep_q;
            last_q <= lastAfter(idx_q + cfgStep_q, cfgStep_q, cfgLast_q);
            if (cfgGap_q != '0) begin
              state_q  <= ST_GAP;
              valid_q  <= 1'b0;
              gapCnt_q <= cfgGap_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign iter_valid_o = valid_q;
  assign iter_idx_o   = idx_q;
  assign iter_last_o  = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_loop_iter_gen.sv
// Directed bench for loop_iter_gen: a scoreboard queue holds the expected index
// stream of each run and a negedge monitor pops and compares every transfer.
module tb_loop_iter_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  cfg_first = '0;
  logic [3:0]  cfg_last = '0;
  logic [3:0]  cfg_step = '0;
  logic [7:0]  cfg_gap = '0;
  logic [15:0] wdog_limit = '0;
  logic        iter_ready = 1'b0;
  logic        iter_valid;
  logic [3:0]  iter_idx;
  logic        iter_last;
  logic        busy;
  logic        done;
  logic        timeout;

  typedef struct {
    int idx;
    int last;
  } expItem_t;

  expItem_t expQ[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int startCyc = 0, prevXferCyc = 0, lastXferCyc = 0, spacingExp = 0;
  int xferCount = 0, doneCount = 0, doneCyc = 0, toCount = 0, toCyc = 0;
  int busyCycles = 0, validCycles = 0;
  logic       prevValid = 1'b0;
  logic       prevXfer = 1'b0;
  logic [3:0] prevIdx = '0;
  logic       prevLast = 1'b0;

  loop_iter_gen #(.IDX_W(4), .GAP_W(8), .WDOG_W(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .cfg_first_i  (cfg_first),
    .cfg_last_i   (cfg_last),
    .cfg_step_i   (cfg_step),
    .cfg_gap_i    (cfg_gap),
    .wdog_limit_i (wdog_limit),
    .iter_valid_o (iter_valid),
    .iter_ready_i (iter_ready),
    .iter_idx_o   (iter_idx),
    .iter_last_o  (iter_last),
    .busy_o       (busy),
    .done_o       (done),
    .timeout_o    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: abort wins over a same-cycle handshake, so that cycle is not a transfer.
  always @(negedge clk) begin
    logic xfer;
    expItem_t e;
    cyc++;
    if (rst_n) begin
      xfer = iter_valid && iter_ready && !abort;
      if (busy) busyCycles++;
      if (iter_valid) validCycles++;
      if (iter_valid && prevValid && !prevXfer) begin
        checkOutput("hold_idx", 32'(iter_idx), 32'(prevIdx));
        checkOutput("hold_last", 32'(iter_last), 32'(prevLast));
      end
      if (xfer) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $error("[TB] FAIL unexpected_xfer: observed idx=%0d expected=no transfer", iter_idx);
        end else begin
          e = expQ.pop_front();
          checkOutput("xfer_idx", 32'(iter_idx), e.idx);
          checkOutput("xfer_last", 32'(iter_last), e.last);
        end
        if (spacingExp != 0) checkOutput("xfer_spacing", cyc - prevXferCyc, spacingExp);
        prevXferCyc = cyc;
        lastXferCyc = cyc;
        xferCount++;
      end
      if (done) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (timeout) begin
        toCount++;
        toCyc = cyc;
      end
      prevValid = iter_valid;
      prevXfer  = xfer;
      prevIdx   = iter_idx;
      prevLast  = iter_last;
    end else begin
      prevValid = 1'b0;
      prevXfer  = 1'b0;
    end
  end

  task automatic applyStimulus(input int first, input int last, input int step,
                               input int gap, input int wdog, input int spacing);
    int eff;
    expItem_t e;
    eff = (step == 0) ? 1 : step;
    for (int i = first; i <= last; i += eff) begin
      e.idx  = i;
      e.last = (i + eff > last) ? 1 : 0;
      expQ.push_back(e);
    end
    xferCount = 0; doneCount = 0; toCount = 0; busyCycles = 0; validCycles = 0;
    spacingExp = spacing;
    cfg_first  = 4'(first);
    cfg_last   = 4'(last);
    cfg_step   = 4'(step);
    cfg_gap    = 8'(gap);
    wdog_limit = 16'(wdog);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    startCyc    = cyc;
    prevXferCyc = cyc;
  endtask

  task automatic waitRunEnd(input int maxCyc, input bit randReady);
    int n;
    n = 0;
    while (busy && n < maxCyc) begin
      if (randReady) iter_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    checkOutput("run_end_in_bound", 32'(n < maxCyc), 1);
    @(posedge clk); #1;
  endtask

  task automatic endRunChecks(input string tag, input int nXfer, input int nBusy);
    checkOutput({tag, "_xfers"}, xferCount, nXfer);
    checkOutput({tag, "_done_count"}, doneCount, 1);
    if (nXfer > 0) checkOutput({tag, "_done_lat"}, doneCyc - lastXferCyc, 1);
    else checkOutput({tag, "_done_lat"}, doneCyc - startCyc, 1);
    checkOutput({tag, "_timeout"}, toCount, 0);
    checkOutput({tag, "_pending"}, expQ.size(), 0);
    if (nBusy >= 0) checkOutput({tag, "_busy_cycles"}, busyCycles, nBusy);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_valid"}, 32'(iter_valid), 0);
    checkOutput({tag, "_idx"}, 32'(iter_idx), 0);
    checkOutput({tag, "_last"}, 32'(iter_last), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkQuiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back run and gapped run
    iter_ready = 1'b1;
    applyStimulus(0, 10, 1, 0, 0, 1);
    waitRunEnd(200, 1'b0);
    endRunChecks("gap0", 11, 11);

    applyStimulus(0, 10, 1, 9, 0, 10);
    waitRunEnd(400, 1'b0);
    endRunChecks("gap9", 11, 110);

    // Random back-pressure, then step 0 behaving as step 1
    applyStimulus(3, 14, 5, 1, 0, 0);
    waitRunEnd(500, 1'b1);
    endRunChecks("step5", 3, -1);
    applyStimulus(3, 14, 0, 0, 0, 0);
    waitRunEnd(500, 1'b1);
    endRunChecks("step0", 12, -1);
    iter_ready = 1'b1;

    // Top-of-range and empty runs
    applyStimulus(12, 15, 3, 0, 0, 1);
    waitRunEnd(100, 1'b0);
    endRunChecks("edge12", 2, 2);
    applyStimulus(14, 15, 3, 0, 0, 1);
    waitRunEnd(100, 1'b0);
    endRunChecks("carry14", 1, 1);
    applyStimulus(5, 2, 1, 0, 0, 1);
    waitRunEnd(100, 1'b0);
    endRunChecks("empty", 0, 0);
    checkOutput("empty_valid_cycles", validCycles, 0);

    // Watchdog fires on a stalled consumer
    iter_ready = 1'b0;
    applyStimulus(0, 10, 1, 0, 100, 0);
    waitRunEnd(300, 1'b0);
    checkOutput("wdog_count", toCount, 1);
    checkOutput("wdog_latency", toCyc - startCyc, 101);
    checkOutput("wdog_no_done", doneCount, 0);
    checkOutput("wdog_xfers", xferCount, 0);
    checkQuiet("wdog_after");
    expQ.delete();
    iter_ready = 1'b1;
    applyStimulus(0, 10, 1, 0, 100, 1);
    waitRunEnd(200, 1'b0);
    endRunChecks("after_wdog", 11, 11);

    // Disabled watchdog, then abort in ISSUE with a same-cycle handshake
    iter_ready = 1'b0;
    applyStimulus(2, 9, 1, 0, 0, 0);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("wdog0_timeout", toCount, 0);
    checkOutput("wdog0_busy", 32'(busy), 1);
    checkOutput("wdog0_idx", 32'(iter_idx), 2);
    abort = 1'b1;
    iter_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    iter_ready = 1'b0;
    checkQuiet("abort_issue");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_issue_xfers", xferCount, 0);
    checkOutput("abort_issue_done", doneCount, 0);
    checkOutput("abort_issue_to", toCount, 0);
    expQ.delete();

    // Abort while waiting out the gap
    iter_ready = 1'b1;
    applyStimulus(0, 5, 1, 20, 0, 21);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkQuiet("abort_gap");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_gap_xfers", xferCount, 0);
    checkOutput("abort_gap_done", doneCount, 0);
    expQ.delete();

    // Reset in the middle of a run
    applyStimulus(0, 15, 1, 2, 0, 3);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkQuiet("midreset");
    checkOutput("midreset_xfers", xferCount, 2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midreset_done", doneCount, 0);
    checkOutput("midreset_busy", 32'(busy), 0);
    expQ.delete();

    // A start pulse while busy must not disturb the running sequence
    applyStimulus(1, 13, 4, 3, 0, 4);
    repeat (5) @(posedge clk);
    #1;
    cfg_first = 4'd0;
    cfg_last  = 4'd15;
    cfg_step  = 4'd1;
    cfg_gap   = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitRunEnd(200, 1'b0);
    endRunChecks("start_busy", 4, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
